piece_queue: RTL and testbench

//  Turns the 32-bit pseudo-random word from hw_rng into a stream of Tetris piece IDs.

---
 rtl/tetris_pkg.sv | 32 +++
 rtl/piece_fifo.sv | 45 ++++
 rtl/piece_queue.sv | 91 +++++++++
 tb/tb_piece_queue.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared piece and queue-FSM types for the Tetris piece generator.
// reroll_piece folds a second draw onto the last piece, modulo 7.
package tetris_pkg;

  localparam int PIECE_W = 3;

  typedef enum logic [PIECE_W-1:0] {
    PIECE_T    = 3'd0,
    PIECE_J    = 3'd1,
    PIECE_Z    = 3'd2,
    PIECE_O    = 3'd3,
    PIECE_S    = 3'd4,
    PIECE_L    = 3'd5,
    PIECE_I    = 3'd6,
    PIECE_NONE = 3'd7
  } piece_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GEN    = 2'd1,
    ST_REROLL = 2'd2,
    ST_READY  = 2'd3
  } pq_state_t;

  function automatic piece_t reroll_piece(input logic [2:0] r, input piece_t last);
    logic [3:0] s;
    s = {1'b0, r} + ((last == PIECE_NONE) ? 4'd0 : {1'b0, last});
    if (s >= 4'd7) s = s - 4'd7;
    return piece_t'(s[2:0]);
  endfunction

endpackage

// File: rtl/piece_fifo.sv
// Shift-register FIFO of upcoming pieces; entry[0] is the head.
// Popping the only entry leaves entry[0] in place so the head value holds.
module piece_fifo
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push,
  input  piece_t     push_val,
  input  logic       pop,
  output piece_t     head,
  output piece_t     second,
  output logic [2:0] count
);

  piece_t     entry [DEPTH];
  logic       pop_ok;
  logic [2:0] wr_idx;

  assign pop_ok = pop && (count != 3'd0);
  assign wr_idx = count - {2'b0, pop_ok};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= PIECE_T;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop_ok && count > 3'd1)
        for (int i = 0; i < DEPTH - 1; i++) entry[i] <= entry[i+1];
      // the push slot is computed after the pop, so it lands at the new tail
      for (int i = 0; i < DEPTH; i++)
        if (push && wr_idx == 3'(i)) entry[i] <= push_val;
      count <= count + {2'b0, push} - {2'b0, pop_ok};
    end
  end

  assign head   = entry[0];
  assign second = entry[1];

endmodule

// File: rtl/piece_queue.sv
// Turns hw_rng words into a queue of Tetris pieces using NES-style single reroll.
// state     | meaning
// ST_IDLE   | after reset, waits for start
// ST_GEN    | draws rand_in[2:0]; pushes it unless it is 7 or a repeat
// ST_REROLL | pushes (rand_in[7:5] + last) mod 7, repeats allowed
// ST_READY  | queue full, waits for a pop
module piece_queue
  import tetris_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        rand_in,
  input  logic               start,
  input  logic               pop,
  output logic [PIECE_W-1:0] head_piece,
  output logic               head_valid,
  output logic [PIECE_W-1:0] preview_piece,
  output logic [2:0]         count,
  output logic               busy
);

  pq_state_t state, state_n;
  piece_t    last, last_n, push_val, cand, fifo_head, fifo_second;
  logic      push, flush, pop_acc;
  logic      rand_unused;

  assign rand_unused = ^{rand_in[31:8], rand_in[4:3]};
  assign cand        = piece_t'(rand_in[2:0]);
  assign pop_acc     = pop && head_valid && !start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      last  <= PIECE_NONE;
    end else begin
      state <= state_n;
      last  <= last_n;
    end
  end

  always_comb begin
    state_n  = state;
    last_n   = last;
    push     = 1'b0;
    push_val = cand;
    flush    = 1'b0;
    if (start) begin
      flush   = 1'b1;
      last_n  = PIECE_NONE;
      state_n = ST_GEN;
    end else begin
      case (state)
        ST_GEN: begin
          if (cand != PIECE_NONE && cand != last) push = 1'b1;
          else state_n = ST_REROLL;
        end
        ST_REROLL: begin
          push     = 1'b1;
          push_val = reroll_piece(rand_in[7:5], last);
        end
        ST_READY: if (pop_acc) state_n = ST_GEN;
        default: ;
      endcase
      if (push) begin
        last_n  = push_val;
        state_n = ((count + {2'b0, push} - {2'b0, pop_acc}) == 3'(QUEUE_DEPTH))
                  ? ST_READY : ST_GEN;
      end
    end
  end

  piece_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .push     (push),
    .push_val (push_val),
    .pop      (pop_acc),
    .head     (fifo_head),
    .second   (fifo_second),
    .count    (count)
  );

  assign head_piece    = fifo_head;
  assign head_valid    = (count != 3'd0);
  assign preview_piece = (count >= 3'd2) ? fifo_second : PIECE_NONE;
  assign busy          = (state == ST_GEN) || (state == ST_REROLL);

endmodule

// File: tb/tb_piece_queue.sv
// Bench for piece_queue: directed cases plus random traffic against a
// queue-based reference model of the piece selection rules.
module tb_piece_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rand_in;
  logic        start;
  logic        pop;
  logic [2:0]  head_piece;
  logic        head_valid;
  logic [2:0]  preview_piece;
  logic [2:0]  count;
  logic        busy;

  int checks = 0;
  int failures = 0;

  // reference model state
  int q[$];
  int last;
  bit filling;
  bit pend;
  int hold;

  piece_queue #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rand_in       (rand_in),
    .start         (start),
    .pop           (pop),
    .head_piece    (head_piece),
    .head_valid    (head_valid),
    .preview_piece (preview_piece),
    .count         (count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    last = 7;
    filling = 0;
    pend = 0;
    hold = 0;
  endtask

  task automatic model_step(input logic s, input logic p, input logic [31:0] r);
    int  v;
    int  c;
    bit  do_push;
    bit  pop_ok;
    if (s) begin
      q.delete();
      last = 7;
      filling = 1;
      pend = 0;
      return;
    end
    pop_ok  = p && (q.size() > 0);
    do_push = 0;
    v = 0;
    if (filling) begin
      if (pend) begin
        v = (int'(r[7:5]) + ((last == 7) ? 0 : last)) % 7;
        do_push = 1;
        pend = 0;
      end else begin
        c = int'(r[2:0]);
        if (c != 7 && c != last) begin
          v = c;
          do_push = 1;
        end else begin
          pend = 1;
        end
      end
    end
    if (pop_ok) begin
      void'(q.pop_front());
      filling = 1;
    end
    if (do_push) begin
      q.push_back(v);
      last = v;
      if (q.size() == DEPTH) filling = 0;
    end
    if (q.size() > 0) hold = q[0];
  endtask

  function automatic logic [10:0] exp_vec();
    logic [2:0] h;
    logic [2:0] pv;
    h  = 3'(hold);
    pv = (q.size() >= 2) ? 3'(q[1]) : 3'd7;
    return {filling, 3'(q.size()), (q.size() > 0), h, pv};
  endfunction

  function automatic logic [10:0] act_vec();
    return {busy, count, head_valid, head_piece, preview_piece};
  endfunction

  function automatic logic [31:0] with_lo(input int v);
    return ($urandom & 32'hFFFF_FFF8) | 32'(v);
  endfunction

  function automatic logic [31:0] with_hi(input int v);
    return ($urandom & 32'hFFFF_FF1F) | (32'(v) << 5);
  endfunction

  task automatic cycle(input logic s, input logic p, input logic [31:0] r);
    @(negedge clk);
    start = s;
    pop = p;
    rand_in = r;
    @(posedge clk);
    model_step(s, p, r);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    pop = 1'b0;
    rand_in = '0;
    model_reset();
    #1;
    checks++;
    if (act_vec() !== 11'b0_000_0_000_111) begin
      failures++;
      $display("FAIL reset_values: got %h expected %h", act_vec(), 11'b0_000_0_000_111);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, 1'b1, $urandom);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL idle_ignores_pop: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_draw_and_reroll();
    cycle(1'b1, 1'b0, $urandom);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL start_flush: got %h expected %h", act_vec(), exp_vec());
    end
    cycle(1'b0, 1'b0, with_lo(3));
    checks++;
    if (head_piece !== 3'd3 || head_valid !== 1'b1 || count !== 3'd1) begin
      failures++;
      $display("FAIL clean_draw_O: got head=%0d valid=%0b count=%0d expected head=3 valid=1 count=1",
               head_piece, head_valid, count);
    end
    cycle(1'b0, 1'b0, with_lo(7));
    checks++;
    if (count !== 3'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reroll_first_cycle: got count=%0d busy=%0b expected count=1 busy=1", count, busy);
    end
    cycle(1'b0, 1'b0, with_hi(5));
    checks++;
    if (count !== 3'd2 || preview_piece !== 3'd1) begin
      failures++;
      $display("FAIL reroll_push_J: got count=%0d preview=%0d expected count=2 preview=1", count, preview_piece);
    end
    cycle(1'b0, 1'b0, with_lo(1));
    checks++;
    if (count !== 3'd2) begin
      failures++;
      $display("FAIL repeat_triggers_reroll: got count=%0d expected 2", count);
    end
    cycle(1'b0, 1'b0, with_hi(0));
    checks++;
    if (act_vec() !== exp_vec() || count !== 3'd3) begin
      failures++;
      $display("FAIL reroll_repeat_allowed: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_fill();
    cycle(1'b1, 1'b0, $urandom);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, with_lo(i));
    checks++;
    if (count !== 3'd4 || busy !== 1'b0 || preview_piece !== 3'd1 || head_piece !== 3'd0) begin
      failures++;
      $display("FAIL fill_to_depth: got count=%0d busy=%0b preview=%0d head=%0d expected 4 0 1 0",
               count, busy, preview_piece, head_piece);
    end
    cycle(1'b0, 1'b0, with_lo(5));
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL full_holds: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_pop();
    cycle(1'b0, 1'b1, with_lo(7));
    checks++;
    if (count !== 3'd3 || head_piece !== 3'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pop_full: got count=%0d head=%0d busy=%0b expected 3 1 1", count, head_piece, busy);
    end
    cycle(1'b0, 1'b0, with_lo(5));
    checks++;
    if (count !== 3'd4 || act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL refill_after_pop: got %h expected %h", act_vec(), exp_vec());
    end
    cycle(1'b1, 1'b1, $urandom);
    checks++;
    if (count !== 3'd0 || head_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_beats_pop: got count=%0d valid=%0b expected 0 0", count, head_valid);
    end
    cycle(1'b0, 1'b1, with_lo(7));
    checks++;
    if (act_vec() !== exp_vec() || count !== 3'd0) begin
      failures++;
      $display("FAIL pop_empty: got %h expected %h", act_vec(), exp_vec());
    end
    cycle(1'b0, 1'b1, $urandom);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL pop_with_push: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_midfill();
    cycle(1'b1, 1'b0, $urandom);
    cycle(1'b0, 1'b0, with_lo(2));
    cycle(1'b0, 1'b0, with_lo(4));
    checks++;
    if (count !== 3'd2) begin
      failures++;
      $display("FAIL midfill_count: got %0d expected 2", count);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act_vec() !== 11'b0_000_0_000_111) begin
      failures++;
      $display("FAIL async_reset: got %h expected %h", act_vec(), 11'b0_000_0_000_111);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, 1'b0, $urandom);
    checks++;
    if (count !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got count=%0d busy=%0b expected 0 0", count, busy);
    end
    cycle(1'b1, 1'b0, $urandom);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, $urandom);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL refill_after_reset[%0d]: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic s;
    logic p;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 99) == 0);
      p = ($urandom_range(0, 2) == 0);
      cycle(s, p, $urandom);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random[%0d]: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_draw_and_reroll();
    test_fill();
    test_pop();
    test_reset_midfill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
